// File: rtl/alarm_annunciator.sv
// Alarm annunciator: escalates upstream TRIGGER/ERROR status into strobe, siren and lockout.
// Optional macro ANNUNC_EVENT_CNT_EN adds EVT_CNT, a saturating count of WARN->ALARM escalations.
module alarm_annunciator #(
    parameter int unsigned WARN_CYC  = 8,
    parameter int unsigned ALARM_CYC = 32,
    parameter int unsigned ERR_MAX   = 3
) (
    input  logic       U,
    input  logic       R_n,
    input  logic [2:0] Z,
    input  logic       ACK,
    output logic       SIREN,
    output logic       STROBE,
    output logic       LOCKOUT,
    output logic [2:0] ERRCNT
`ifdef ANNUNC_EVENT_CNT_EN
    ,
    output logic [7:0] EVT_CNT
`endif
);

    localparam int unsigned MAX_CYC = (WARN_CYC > ALARM_CYC) ? WARN_CYC : ALARM_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [2:0] Z_OFF      = 3'b000;
    localparam logic [2:0] Z_UNLOCKED = 3'b100;
    localparam logic [2:0] Z_TRIGGER  = 3'b101;
    localparam logic [2:0] Z_ERROR    = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WARN     = 3'd1,
        S_ALARM    = 3'd2,
        S_SILENCED = 3'd3,
        S_LOCKOUT  = 3'd4
    } state_t;

    state_t             state, state_nx;
    logic [2:0]         z_q, z_prev;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic [1:0]         phase, phase_nx;
    logic [2:0]         errcnt_nx;
    logic               siren_nx, strobe_nx, lockout_nx;
    logic               err_entry, trig_entry, is_clear, lock_go;

    // Status capture; z_prev lets us detect fresh entries into a code
    always_ff @(posedge U or negedge R_n) begin
        if (!R_n) begin
            z_q    <= 3'b000;
            z_prev <= 3'b000;
        end else begin
            z_q    <= Z;
            z_prev <= z_q;
        end
    end

    always_ff @(posedge U or negedge R_n) begin
        if (!R_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            phase   <= '0;
            ERRCNT  <= '0;
            SIREN   <= 1'b0;
            STROBE  <= 1'b0;
            LOCKOUT <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            phase   <= phase_nx;
            ERRCNT  <= errcnt_nx;
            SIREN   <= siren_nx;
            STROBE  <= strobe_nx;
            LOCKOUT <= lockout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        phase_nx   = 2'd0;
        errcnt_nx  = ERRCNT;
        strobe_nx  = 1'b0;
        err_entry  = (z_q == Z_ERROR) && (z_prev != Z_ERROR);
        trig_entry = (z_q == Z_TRIGGER) && (z_prev != Z_TRIGGER);
        is_clear   = (z_q == Z_UNLOCKED) || (z_q == Z_OFF);
        lock_go    = err_entry && (ERRCNT != 3'd7) && ((32'(ERRCNT) + 32'd1) == ERR_MAX);

        if (err_entry && (ERRCNT != 3'd7)) begin
            errcnt_nx = ERRCNT + 3'd1;
        end else if (is_clear && (state != S_LOCKOUT)) begin
            errcnt_nx = 3'd0;
        end

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (z_q == Z_TRIGGER) begin
                    state_nx = S_WARN;
                    cnt_nx   = CNT_W'(WARN_CYC - 1);
                end
            end
            S_WARN: begin
                if (is_clear) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == '0) begin
                    state_nx = S_ALARM;
                    cnt_nx   = CNT_W'(ALARM_CYC - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_ALARM: begin
                // UNLOCKED/OFF beat ACK, which beats timeout
                if (is_clear) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (ACK || (cnt == '0)) begin
                    state_nx = S_SILENCED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            S_SILENCED: begin
                if (is_clear) begin
                    state_nx = S_IDLE;
                end else if (trig_entry) begin
                    state_nx = S_WARN;
                    cnt_nx   = CNT_W'(WARN_CYC - 1);
                end
            end
            S_LOCKOUT: begin
                if (ACK && (z_q == Z_UNLOCKED)) begin
                    state_nx  = S_IDLE;
                    errcnt_nx = 3'd0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase

        if (lock_go) begin
            state_nx = S_LOCKOUT;
            cnt_nx   = '0;
        end

        siren_nx   = (state_nx == S_ALARM) || (state_nx == S_LOCKOUT);
        lockout_nx = (state_nx == S_LOCKOUT);

        // Strobe starts high on entering WARN/SILENCED, then blinks at 1 or 4 cycles
        case (state_nx)
            S_WARN:     strobe_nx = (state == S_WARN) ? ~STROBE : 1'b1;
            S_SILENCED: begin
                if (state != S_SILENCED) begin
                    strobe_nx = 1'b1;
                end else begin
                    phase_nx  = phase + 2'd1;
                    strobe_nx = (phase == 2'd3) ? ~STROBE : STROBE;
                end
            end
            S_ALARM, S_LOCKOUT: strobe_nx = 1'b1;
            default:            strobe_nx = 1'b0;
        endcase
    end

`ifdef ANNUNC_EVENT_CNT_EN
    always_ff @(posedge U or negedge R_n) begin
        if (!R_n) begin
            EVT_CNT <= 8'd0;
        end else if ((state == S_WARN) && (state_nx == S_ALARM) && (EVT_CNT != 8'd255)) begin
            EVT_CNT <= EVT_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alarm_annunciator.sv
// Directed self-checking bench for alarm_annunciator with default parameters.
module tb_alarm_annunciator;

    logic       U;
    logic       R_n;
    logic [2:0] Z;
    logic       ACK;
    logic       SIREN, STROBE, LOCKOUT;
    logic [2:0] ERRCNT;
`ifdef ANNUNC_EVENT_CNT_EN
    logic [7:0] EVT_CNT;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alarm_annunciator dut (
        .U       (U),
        .R_n     (R_n),
        .Z       (Z),
        .ACK     (ACK),
        .SIREN   (SIREN),
        .STROBE  (STROBE),
        .LOCKOUT (LOCKOUT),
        .ERRCNT  (ERRCNT)
`ifdef ANNUNC_EVENT_CNT_EN
        ,
        .EVT_CNT (EVT_CNT)
`endif
    );

    initial U = 1'b0;
    always #5 U = ~U;

    task automatic tick();
        @(posedge U);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        int   cnt;
        R_n = 1'b0; Z = 3'b000; ACK = 1'b0;
        #12;
        chk("rst_siren", 8'(SIREN), 8'd0);
        chk("rst_strobe", 8'(STROBE), 8'd0);
        chk("rst_lockout", 8'(LOCKOUT), 8'd0);
        chk("rst_errcnt", 8'(ERRCNT), 8'd0);
        R_n = 1'b1;

        // escalation: WARN at edge 1, siren from edge 9
        Z = 3'b101;
        tick();
        chk("esc_e0_strobe", 8'(STROBE), 8'd0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("esc_warn_strobe", 8'(STROBE), 8'(i % 2));
            chk("esc_warn_siren", 8'(SIREN), 8'd0);
        end
        tick();
        chk("esc_e9_siren", 8'(SIREN), 8'd1);
        chk("esc_e9_strobe", 8'(STROBE), 8'd1);
        tick();
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("ack_siren", 8'(SIREN), 8'd0);
        chk("ack_strobe", 8'(STROBE), 8'd1);
        tick(); tick(); tick();
        chk("sil_strobe_hi", 8'(STROBE), 8'd1);
        tick();
        chk("sil_strobe_lo", 8'(STROBE), 8'd0);
        chk("sil_held_trig", 8'(SIREN), 8'd0);
        Z = 3'b100; tick(); tick();
        chk("sil_unlock_strobe", 8'(STROBE), 8'd0);
        Z = 3'b001; tick();

        // abort during WARN
        Z = 3'b101; tick();
        seen = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick(); seen = seen | SIREN;
        end
        Z = 3'b100;
        tick(); seen = seen | SIREN;
        tick(); seen = seen | SIREN;
        chk("abort_siren_never", 8'(seen), 8'd0);
        chk("abort_strobe", 8'(STROBE), 8'd0);
        Z = 3'b001; tick();
        chk("abort_idle_strobe", 8'(STROBE), 8'd0);

        // timeout: 32 cycles of siren then SILENCED
        Z = 3'b101; tick();
        repeat (9) tick();
        cnt = 0;
        while (SIREN && (cnt < 60)) begin
            cnt++; tick();
        end
        chk("timeout_len", 8'(cnt), 8'd32);
        chk("timeout_strobe", 8'(STROBE), 8'd1);
        Z = 3'b000; tick(); tick();
        chk("off_from_sil", 8'(STROBE), 8'd0);

        // UNLOCKED outranks ACK in ALARM
        Z = 3'b101; tick();
        repeat (9) tick();
        chk("prio_alarm", 8'(SIREN), 8'd1);
        Z = 3'b100; tick();
        ACK = 1'b1; tick(); ACK = 1'b0;
        chk("prio_siren", 8'(SIREN), 8'd0);
        chk("prio_strobe", 8'(STROBE), 8'd0);

        // lockout after three ERROR entries
        Z = 3'b001; tick();
        for (int k = 1; k <= 3; k++) begin
            Z = 3'b110; tick(); tick();
            chk("lk_errcnt", 8'(ERRCNT), 8'(k));
            chk("lk_lockout", 8'(LOCKOUT), 8'(k == 3));
            chk("lk_siren", 8'(SIREN), 8'(k == 3));
            Z = 3'b001; tick();
        end
        Z = 3'b000; tick(); tick();
        chk("lk_off_hold", 8'(LOCKOUT), 8'd1);
        chk("lk_off_errcnt", 8'(ERRCNT), 8'd3);
        ACK = 1'b1; Z = 3'b001; tick(); tick();
        chk("lk_ack_hold", 8'(LOCKOUT), 8'd1);
        Z = 3'b100; tick();
        chk("lk_ack_old_z", 8'(LOCKOUT), 8'd1);
        tick();
        ACK = 1'b0;
        chk("lk_exit", 8'(LOCKOUT), 8'd0);
        chk("lk_exit_errcnt", 8'(ERRCNT), 8'd0);
        chk("lk_exit_siren", 8'(SIREN), 8'd0);

        // held ERROR counts once
        Z = 3'b110;
        repeat (10) tick();
        chk("held_errcnt", 8'(ERRCNT), 8'd1);
        chk("held_lockout", 8'(LOCKOUT), 8'd0);
        Z = 3'b000; tick(); tick();
        chk("held_clear", 8'(ERRCNT), 8'd0);

        // asynchronous reset mid-ALARM
        Z = 3'b101; tick();
        repeat (9) tick();
        chk("rm_alarm", 8'(SIREN), 8'd1);
`ifdef ANNUNC_EVENT_CNT_EN
        chk("rm_evt_pre", EVT_CNT, 8'd4);
`endif
        #2 R_n = 1'b0;
        #1;
        chk("rm_siren_now", 8'(SIREN), 8'd0);
        chk("rm_strobe_now", 8'(STROBE), 8'd0);
`ifdef ANNUNC_EVENT_CNT_EN
        chk("rm_evt_clr", EVT_CNT, 8'd0);
`endif
        Z = 3'b000;
        #1 R_n = 1'b1;
        tick(); tick();
        chk("rm_idle_siren", 8'(SIREN), 8'd0);
        chk("rm_idle_strobe", 8'(STROBE), 8'd0);
        chk("rm_idle_lockout", 8'(LOCKOUT), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
